button_conditioner: RTL and testbench
=====================================

BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 SHALL have parameter N_BTN, default 4, number of push-button channels (1..8).
REQ-002 SHALL have parameter DEBOUNCE_CYCLES, default 500000, stable-input cycles required to accept a level change (10 ms at 50 MHz).
REQ-003 SHALL have parameter CNT_W, default 20, debounce counter width; it SHALL satisfy 2^CNT_W > DEBOUNCE_CYCLES.
REQ-004 clk  input  1  system clock; one clock domain; all state on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 btn_n_in  input  N_BTN  raw board keys, active-low, asynchronous to clk, bouncing.
REQ-007 ack_in  input  N_BTN  host acknowledge, driven from a PIO output word; a rising edge on bit i clears the channel-i sticky events.
REQ-008 status_out  output  32  status word consumed by the push-button PIO input port.

Function
REQ-009 Each btn_n_in bit SHALL pass through a 2-flop synchronizer and then be inverted to give pressed = 1.
REQ-010 Each channel SHALL run an FSM with states RELEASED, WAIT_PRESS, PRESSED, WAIT_RELEASE.
REQ-011 RELEASED->WAIT_PRESS on sync pressed=1, counter cleared.
REQ-012 WAIT_PRESS: counter increments each cycle while pressed=1; pressed=0 returns to RELEASED.
REQ-013 WAIT_PRESS: counter = DEBOUNCE_CYCLES-1 with pressed=1 goes to PRESSED and emits a one-cycle press pulse.
REQ-014 PRESSED and WAIT_RELEASE SHALL mirror REQ-011..013 with the polarity inverted, emitting a release pulse on entry to RELEASED.
REQ-015 Latency from a clean raw edge to the debounced level change SHALL be exactly 2 + DEBOUNCE_CYCLES + 1 cycles.
REQ-016 A bounce shorter than DEBOUNCE_CYCLES SHALL produce no level change and no event.
REQ-017 status_out[N_BTN-1:0] SHALL be the debounced level (1 in PRESSED and WAIT_RELEASE).
REQ-018 status_out[8+i] SHALL be sticky press event i, set by the press pulse.
REQ-019 status_out[16+i] SHALL be sticky release event i, set by the release pulse.
REQ-020 status_out[31:24] SHALL be an 8-bit press count covering all channels, incremented once per press pulse and wrapping 255->0.
REQ-021 Simultaneous press pulses on k channels in one cycle SHALL add k to the count.
REQ-022 All other status_out bits SHALL read 0.
REQ-023 ack_in SHALL be registered once (ack_q), and rising edge = ack_in & ~ack_q.
REQ-024 An ack rising edge SHALL clear sticky bits 8+i and 16+i on the next clock.
REQ-025 When a set pulse and an ack edge hit the same bit in one cycle, set SHALL win.
REQ-026 A held-high ack_in SHALL clear only once.
REQ-027 status_out SHALL be fully registered, with no combinational path from any input.

Reset
REQ-028 Reset asserted SHALL, asynchronously, return all FSMs to RELEASED and zero all counters, sticky bits, press count, ack_q and status_out.
REQ-029 Synchronizer flops SHALL reset to 1 (released) so that releasing reset with keys up produces no event.
REQ-030 Reset mid-debounce SHALL discard the partial count; a key held through reset deassertion SHALL be re-qualified from RELEASED with the full latency of REQ-015.

Structure
REQ-031 Package button_conditioner_pkg SHALL hold the FSM state enum and the status field offsets (LEVEL_LSB=0, PRESS_LSB=8, REL_LSB=16, COUNT_LSB=24).
REQ-032 Sub-module debounce_channel (synchronizer, FSM, counter, press/release pulses) SHALL be instantiated N_BTN times.
REQ-033 The top level SHALL hold the sticky bits, ack logic, press counter and status register.

Verification (bench uses DEBOUNCE_CYCLES=8, N_BTN=4)
REQ-034 Clean press: btn_n_in[0] 1->0 held 20 cycles -> status_out[0]=1 and [8]=1 exactly 11 cycles after the edge, count=1.
REQ-035 Bounce: btn_n_in[1] toggles every 3 cycles for 30 cycles, then stays 1 -> status_out stays 0x00000000.
REQ-036 Release and ack: after the REQ-034 press, release key 0 and wait 11 cycles -> bits [0]=0, [8]=1, [16]=1; pulse ack_in[0] -> bits 8 and 16 clear on the next clock and stay clear with ack_in held high.
REQ-037 Set-wins: drive the ack_in[2] edge in the same cycle as the channel-2 press pulse -> status_out[10]=1 afterwards.
REQ-038 Wrap and simultaneous events: 127 presses on all four keys together (508 press pulses) -> count = 508 mod 256 = 252; two more single presses -> 254, then 255, and a further press -> 0.
REQ-039 Reset mid-operation: assert reset at cycle 5 of WAIT_PRESS with the key held, deassert -> status_out=0 immediately, and the press is reported 11 cycles after deassertion.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared types and status-word layout for the push-button conditioner.
// The status word is read directly by the push-button PIO input port.
package button_conditioner_pkg;

  typedef enum logic [1:0] {
    ST_RELEASED,
    ST_WAIT_PRESS,
    ST_PRESSED,
    ST_WAIT_RELEASE
  } btn_state_e;

  localparam int LEVEL_LSB = 0;
  localparam int PRESS_LSB = 8;
  localparam int REL_LSB   = 16;
  localparam int COUNT_LSB = 24;
  localparam int COUNT_W   = 8;

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One push-button channel: 2-flop synchronizer, debounce FSM and counter.
// Outputs are next-state values so the top-level status register lines up with the FSM.
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n_in,
  output logic level_nxt,
  output logic press_evt,
  output logic release_evt
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q, sync_d;
  btn_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed;

  assign sync_d  = {sync_q[0], btn_n_in};
  assign pressed = ~sync_q[1];

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state_q)
      ST_RELEASED: if (pressed) begin
        state_d = ST_WAIT_PRESS;
        cnt_d   = '0;
      end
      ST_WAIT_PRESS: begin
        if (!pressed) begin
          state_d = ST_RELEASED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_PRESSED;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_PRESSED: if (!pressed) begin
        state_d = ST_WAIT_RELEASE;
        cnt_d   = '0;
      end
      ST_WAIT_RELEASE: begin
        if (pressed) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d     = ST_RELEASED;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ST_RELEASED;
    endcase
  end

  assign level_nxt = (state_d == ST_PRESSED) || (state_d == ST_WAIT_RELEASE);

  // NOTE: sequential state uses non-blocking assignments only, so flop order never matters.
  // Synchronizer resets to "released" so leaving reset with keys up is silent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= 2'b11;
      state_q <= ST_RELEASED;
      cnt_q   <= '0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner: N_BTN debounced channels feeding a registered status word
// with level bits, sticky press/release events (cleared by ack rising edge) and a press count.
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_n_in,
  input  logic [N_BTN-1:0] ack_in,
  output logic [31:0]      status_out
);

  logic [N_BTN-1:0]   level_nxt, press_evt, release_evt;
  logic [N_BTN-1:0]   ack_q, ack_rise;
  logic [31:0]        status_q, status_d;
  logic [COUNT_W-1:0] press_cnt;

  for (genvar g = 0; g < N_BTN; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_ch (
      .clk        (clk),
      .rst        (reset),
      .btn_n_in   (btn_n_in[g]),
      .level_nxt  (level_nxt[g]),
      .press_evt  (press_evt[g]),
      .release_evt(release_evt[g])
    );
  end

  assign ack_rise = ack_in & ~ack_q;

  always_comb begin
    status_d  = '0;
    press_cnt = '0;
    for (int i = 0; i < N_BTN; i++) begin
      status_d[LEVEL_LSB+i] = level_nxt[i];
      // Set is OR-ed in after the clear so a coincident event is never lost.
      status_d[PRESS_LSB+i] = (status_q[PRESS_LSB+i] & ~ack_rise[i]) | press_evt[i];
      status_d[REL_LSB+i]   = (status_q[REL_LSB+i] & ~ack_rise[i]) | release_evt[i];
      press_cnt             = press_cnt + COUNT_W'(press_evt[i]);
    end
    status_d[COUNT_LSB +: COUNT_W] = status_q[COUNT_LSB +: COUNT_W] + press_cnt;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ack_q    <= '0;
      status_q <= '0;
    end else begin
      ack_q    <= ack_in;
      status_q <= status_d;
    end
  end

  assign status_out = status_q;

endmodule

// File: tb/tb_button_conditioner.sv
// Directed self-checking bench for button_conditioner (N_BTN=4, DEBOUNCE_CYCLES=8).
module tb_button_conditioner;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  btn_n_in;
  logic [3:0]  ack_in;
  logic [31:0] status_out;

  int n_checks = 0;
  int n_pass   = 0;

  button_conditioner #(
    .N_BTN          (4),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_n_in  (btn_n_in),
    .ack_in    (ack_in),
    .status_out(status_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual === expected) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, actual, expected);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    tick(1);
  endtask

  initial begin
    reset    = 1'b1;
    btn_n_in = 4'hF;
    ack_in   = 4'h0;
    tick(3);
    reset = 1'b0;
    tick(1);
    check("reset_state", status_out, 32'h0000_0000);
    tick(5);
    check("idle_after_reset", status_out, 32'h0000_0000);

    // Bounce on key 1: 3-cycle pulses never satisfy the 8-cycle window.
    for (int t = 0; t < 10; t++) begin
      btn_n_in[1] = ~btn_n_in[1];
      tick(3);
    end
    btn_n_in[1] = 1'b1;
    check("bounce_mid", status_out, 32'h0000_0000);
    tick(12);
    check("bounce_end", status_out, 32'h0000_0000);

    // Clean press on key 0: level and sticky appear exactly 11 cycles after the edge.
    btn_n_in[0] = 1'b0;
    tick(10);
    check("press_cycle10", status_out, 32'h0000_0000);
    tick(1);
    check("press_cycle11", status_out, 32'h0100_0101);
    tick(9);
    check("press_held", status_out, 32'h0100_0101);

    // Release key 0, then acknowledge.
    btn_n_in[0] = 1'b1;
    tick(10);
    check("release_cycle10", status_out, 32'h0100_0101);
    tick(1);
    check("release_cycle11", status_out, 32'h0101_0100);
    ack_in[0] = 1'b1;
    tick(1);
    check("ack_clear", status_out, 32'h0100_0000);
    tick(3);
    check("ack_held", status_out, 32'h0100_0000);
    ack_in[0] = 1'b0;
    tick(1);

    // Set wins: ack edge on channel 2 in the same cycle as its press pulse.
    btn_n_in[2] = 1'b0;
    tick(10);
    check("setwin_before", status_out, 32'h0100_0000);
    ack_in[2] = 1'b1;
    tick(1);
    check("setwin_after", status_out, 32'h0200_0404);
    btn_n_in[2] = 1'b1;
    tick(11);
    check("ch2_release", status_out, 32'h0204_0400);
    ack_in[2] = 1'b0;
    tick(1);
    ack_in[2] = 1'b1;
    tick(1);
    check("ch2_ack", status_out, 32'h0200_0000);
    ack_in[2] = 1'b0;
    tick(1);

    // Wrap: 127 presses on all four keys together, from a fresh reset.
    do_reset();
    check("reset_before_wrap", status_out, 32'h0000_0000);
    for (int p = 0; p < 127; p++) begin
      btn_n_in = 4'h0;
      tick(12);
      if (p == 0) check("four_at_once", status_out, 32'h0400_0F0F);
      btn_n_in = 4'hF;
      tick(12);
    end
    check("wrap_252", status_out, 32'hFC0F_0F00);
    for (int p = 0; p < 4; p++) begin
      btn_n_in[0] = 1'b0;
      tick(12);
      btn_n_in[0] = 1'b1;
      tick(12);
      if (p == 1) check("count_254", {24'h0, status_out[31:24]}, 32'd254);
      if (p == 2) check("count_255", {24'h0, status_out[31:24]}, 32'd255);
      if (p == 3) check("count_wrap0", {24'h0, status_out[31:24]}, 32'd0);
    end

    // Reset mid-debounce on key 1 with the key held through deassertion.
    btn_n_in[1] = 1'b0;
    tick(8);
    reset = 1'b1;
    #1;
    check("async_reset", status_out, 32'h0000_0000);
    tick(2);
    reset = 1'b0;
    check("after_deassert", status_out, 32'h0000_0000);
    tick(10);
    check("requal_cycle10", status_out, 32'h0000_0000);
    tick(1);
    check("requal_cycle11", status_out, 32'h0100_0202);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
